pll_lock_monitor: RTL

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_mon_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_monitor.sv | 99 +++++++++
 3 files changed

// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor: FSM encoding, parameter defaults
// and a small saturating-increment helper.
package pll_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } pll_state_e;

  localparam int unsigned SETTLE_CYCLES_DEF    = 1024;
  localparam int unsigned LOST_HOLD_CYCLES_DEF = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with asynchronous
// active-low reset that clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Watches the PLL lock, holds downstream logic in reset until lock has been
// stable long enough, and counts lock losses while running.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = SETTLE_CYCLES_DEF,
  parameter int unsigned LOST_HOLD_CYCLES = LOST_HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       clear_loss,
  output logic       sys_reset_n,
  output logic       locked,
  output logic [7:0] loss_count,
  output logic [2:0] state
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST   = 8'(LOST_HOLD_CYCLES - 1);

  pll_state_e  state_q, state_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  loss_count_q, loss_count_d;
  logic        sys_reset_n_q, sys_reset_n_d;
  logic        locked_sync;
  logic        enter_lost;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (pll_lock),
    .q     (locked_sync)
  );

  // State and datapath registers; everything clears asynchronously so the
  // downstream reset drops the instant the block reset does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      hold_cnt_q    <= '0;
      loss_count_q  <= '0;
      sys_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      loss_count_q  <= loss_count_d;
      sys_reset_n_q <= sys_reset_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (locked_sync) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!locked_sync)                   state_d = ST_WAIT_LOCK;
        else if (settle_cnt_q == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN:       if (!locked_sync) state_d = ST_LOST;
      ST_LOST:      if (hold_cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    loss_count_d = loss_count_q;
    enter_lost   = (state_q == ST_RUN) && (state_d == ST_LOST);

    case (state_q)
      ST_WAIT_LOCK: settle_cnt_d = '0;
      ST_SETTLE:    settle_cnt_d = settle_cnt_q + 16'd1;
      ST_LOST:      hold_cnt_d   = hold_cnt_q + 8'd1;
      default:      ;
    endcase

    // A clear landing on the loss edge still records that loss.
    if (enter_lost) begin
      hold_cnt_d   = '0;
      loss_count_d = clear_loss ? 8'd1 : sat_inc8(loss_count_q);
    end else if (clear_loss) begin
      loss_count_d = '0;
    end

    sys_reset_n_d = (state_d == ST_RUN);
  end

  assign sys_reset_n = sys_reset_n_q;
  assign locked      = locked_sync;
  assign loss_count  = loss_count_q;
  assign state       = state_q;

endmodule
